// File: rtl/pipe_arb_pkg.sv
// Shared constants and helpers for the pipelined round-robin arbiter.
package pipe_arb_pkg;

  localparam int                   CNT_WIDTH = 16;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = 16'hFFFF;

  // Requester-index width, never narrower than one bit.
  function automatic int tag_width(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/pipe_arbiter_valid_delay.sv
// Fixed-depth shift line carrying {valid, tag}, aligned with the shared datapath.
// Only the valid bits are cleared by the synchronous active-low reset.
module valid_delay #(
  parameter int DEPTH = 2,
  parameter int TAG_W = 1
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             valid_in,
  input  logic [TAG_W-1:0] tag_in,
  output logic             valid_out,
  output logic [TAG_W-1:0] tag_out,
  output logic             any_valid_out
);

  logic [DEPTH-1:0]            valid_q;
  logic [DEPTH-1:0][TAG_W-1:0] tag_q;

  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples its predecessor's pre-edge value and the line shifts by one.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      valid_q <= '0;
    end else begin
      valid_q[0] <= valid_in;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
      end
    end
  end

  // NOTE: tags are payload qualified by valid_q, so they carry no reset;
  // clearing the valids alone is enough to drop in-flight transfers.
  always_ff @(posedge clk_in) begin
    tag_q[0] <= tag_in;
    for (int i = 1; i < DEPTH; i++) begin
      tag_q[i] <= tag_q[i-1];
    end
  end

  assign valid_out     = valid_q[DEPTH-1];
  assign tag_out       = tag_q[DEPTH-1];
  assign any_valid_out = |valid_q;

endmodule

// File: rtl/pipe_arbiter.sv
// Round-robin arbiter sharing one fixed-latency datapath among NUM_REQ requesters.
// Optional macro PIPE_ARB_CNT_EN adds saturating per-requester grant counters.
module pipe_arbiter
  import pipe_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int WIDTH   = 16,
  parameter int LATENCY = 2
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic [NUM_REQ-1:0]            req_valid_in,
  input  logic [NUM_REQ-1:0][WIDTH-1:0] req_data_in,
  output logic [NUM_REQ-1:0]            req_ready_out,
  output logic                          dp_valid_out,
  output logic [WIDTH-1:0]              dp_data_out,
  input  logic [WIDTH-1:0]              dp_data_in,
  output logic [NUM_REQ-1:0]            rsp_valid_out,
  output logic [WIDTH-1:0]              rsp_data_out,
  output logic                          busy_out
`ifdef PIPE_ARB_CNT_EN
  ,
  output logic [NUM_REQ-1:0][CNT_WIDTH-1:0] grant_cnt_out
`endif
);

  localparam int TAG_W = tag_width(NUM_REQ);

  logic [TAG_W-1:0] last_grant;
  logic [TAG_W-1:0] grant_idx;
  logic [TAG_W-1:0] cand;
  logic             found;
  logic             handshake;
  logic [TAG_W-1:0] dp_tag;
  logic             dl_valid;
  logic [TAG_W-1:0] dl_tag;
  logic             dl_any;

  // Search starts one past the last winner; grants are forced low in reset.
  // NOTE: every always_comb output gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    req_ready_out = '0;
    grant_idx     = '0;
    cand          = '0;
    found         = 1'b0;
    if (rst_in) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        cand = TAG_W'((int'(last_grant) + k) % NUM_REQ);
        if (!found && req_valid_in[cand]) begin
          found                = 1'b1;
          grant_idx            = cand;
          req_ready_out[cand]  = 1'b1;
        end
      end
    end
  end

  assign handshake = |req_ready_out;

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      last_grant   <= TAG_W'(NUM_REQ - 1);
      dp_valid_out <= 1'b0;
      dp_data_out  <= '0;
      dp_tag       <= '0;
    end else begin
      dp_valid_out <= handshake;
      if (handshake) begin
        last_grant  <= grant_idx;
        dp_data_out <= req_data_in[grant_idx];
        dp_tag      <= grant_idx;
      end
    end
  end

  valid_delay #(
    .DEPTH (LATENCY),
    .TAG_W (TAG_W)
  ) u_valid_delay (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .valid_in      (dp_valid_out),
    .tag_in        (dp_tag),
    .valid_out     (dl_valid),
    .tag_out       (dl_tag),
    .any_valid_out (dl_any)
  );

  always_comb begin
    rsp_valid_out = '0;
    if (dl_valid) begin
      rsp_valid_out[dl_tag] = 1'b1;
    end
  end

  assign rsp_data_out = dp_data_in;
  assign busy_out     = dp_valid_out | dl_any;

`ifdef PIPE_ARB_CNT_EN
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      grant_cnt_out <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_ready_out[i] && grant_cnt_out[i] != CNT_MAX) begin
          grant_cnt_out[i] <= grant_cnt_out[i] + 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_arbiter.sv
// Directed self-checking bench for pipe_arbiter (2-requester and 4-requester instances).
// Define PIPE_ARB_CNT_EN to also exercise the grant counters.
module tb_pipe_arbiter;

  logic              clk_in = 1'b0;
  logic              rst_in;

  logic [1:0]        req_valid;
  logic [1:0][15:0]  req_data;
  logic [1:0]        req_ready;
  logic              dp_valid;
  logic [15:0]       dp_data;
  logic [15:0]       dp_data_in;
  logic [1:0]        rsp_valid;
  logic [15:0]       rsp_data;
  logic              busy;

  logic [3:0]        req_valid4;
  logic [3:0][15:0]  req_data4;
  logic [3:0]        req_ready4;
  logic              dp_valid4;
  logic [15:0]       dp_data4;
  logic [3:0]        rsp_valid4;
  logic [15:0]       rsp_data4;
  logic              busy4;

`ifdef PIPE_ARB_CNT_EN
  logic [1:0][15:0]  grant_cnt;
  logic [3:0][15:0]  grant_cnt4;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_in = ~clk_in;

  // Echo datapath with a two-cycle latency.
  logic [15:0] echo_d1, echo_d2;
  always @(posedge clk_in) begin
    echo_d1 <= dp_data;
    echo_d2 <= echo_d1;
  end
  assign dp_data_in = echo_d2;

  pipe_arbiter u_dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .req_valid_in  (req_valid),
    .req_data_in   (req_data),
    .req_ready_out (req_ready),
    .dp_valid_out  (dp_valid),
    .dp_data_out   (dp_data),
    .dp_data_in    (dp_data_in),
    .rsp_valid_out (rsp_valid),
    .rsp_data_out  (rsp_data),
    .busy_out      (busy)
`ifdef PIPE_ARB_CNT_EN
    ,
    .grant_cnt_out (grant_cnt)
`endif
  );

  pipe_arbiter #(.NUM_REQ(4)) u_dut4 (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .req_valid_in  (req_valid4),
    .req_data_in   (req_data4),
    .req_ready_out (req_ready4),
    .dp_valid_out  (dp_valid4),
    .dp_data_out   (dp_data4),
    .dp_data_in    (dp_data4),
    .rsp_valid_out (rsp_valid4),
    .rsp_data_out  (rsp_data4),
    .busy_out      (busy4)
`ifdef PIPE_ARB_CNT_EN
    ,
    .grant_cnt_out (grant_cnt4)
`endif
  );

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_in     = 1'b0;
    req_valid  = 2'b11;
    req_data   = '0;
    req_data[0] = 16'h1111;
    req_data[1] = 16'h2222;
    req_valid4 = '0;
    req_data4  = '0;

    // Reset state, with requests held high to prove grants are masked.
    tick(); tick();
    check("rst_ready",    req_ready, 2'b00);
    check("rst_dp_valid", dp_valid,  1'b0);
    check("rst_dp_data",  dp_data,   16'h0000);
    check("rst_busy",     busy,      1'b0);
    check("rst_rsp",      rsp_valid, 2'b00);
    check("rst_busy4",    busy4,     1'b0);

    // Both requesting: grants alternate 0,1,0,1 with no bubble.
    rst_in = 1'b1;
    #1;
    check("rr_a_ready", req_ready, 2'b01);
    check("rr_a_rsp",   rsp_valid, 2'b00);
    tick();
    check("rr_b_dpv",   dp_valid,  1'b1);
    check("rr_b_dpd",   dp_data,   16'h1111);
    check("rr_b_ready", req_ready, 2'b10);
    tick();
    check("rr_c_dpd",   dp_data,   16'h2222);
    check("rr_c_ready", req_ready, 2'b01);
    check("rr_c_rsp",   rsp_valid, 2'b00);
    tick();
    check("rr_d_dpd",   dp_data,   16'h1111);
    check("rr_d_ready", req_ready, 2'b10);
    check("rr_d_rsp",   rsp_valid, 2'b01);
    check("rr_d_rspd",  rsp_data,  16'h1111);
    tick();
    check("rr_e_dpd",   dp_data,   16'h2222);
    check("rr_e_rsp",   rsp_valid, 2'b10);
    check("rr_e_rspd",  rsp_data,  16'h2222);
    req_valid = 2'b00;
    #1;
    check("idle_ready", req_ready, 2'b00);
    tick();
    check("idle_dpv",   dp_valid,  1'b0);
    check("hold_dpd",   dp_data,   16'h2222);
    check("rr_f_rsp",   rsp_valid, 2'b01);
    check("rr_f_busy",  busy,      1'b1);
    tick();
    check("rr_g_rsp",   rsp_valid, 2'b10);
    check("rr_g_busy",  busy,      1'b1);
    tick();
    check("rr_h_rsp",   rsp_valid, 2'b00);
    check("rr_h_busy",  busy,      1'b0);

    // Single handshake from requester 1; response lands three cycles later.
    req_valid   = 2'b10;
    req_data[1] = 16'h00A5;
    #1;
    check("one_ready", req_ready, 2'b10);
    tick();
    req_valid = 2'b00;
    check("one_dpv",   dp_valid,  1'b1);
    check("one_dpd",   dp_data,   16'h00A5);
    check("one_rsp1",  rsp_valid, 2'b00);
    tick();
    check("one_rsp2",  rsp_valid, 2'b00);
    tick();
    check("one_rsp3",  rsp_valid, 2'b10);
    check("one_rspd",  rsp_data,  16'h00A5);
    tick();
    check("one_rsp4",  rsp_valid, 2'b00);

    // Four requesters, only requester 2 active for five cycles.
    check("r4_idle", req_ready4, 4'b0000);
    req_valid4 = 4'b0100;
    for (int i = 0; i < 5; i++) begin
      req_data4[2] = 16'h0300 + 16'(i);
      #1;
      check($sformatf("r4_grant%0d", i), req_ready4, 4'b0100);
      tick();
      check($sformatf("r4_dpd%0d", i), dp_data4, 16'h0300 + 16'(i));
    end
    // Rotation from last winner 2: 3, then 0, then 1, then 3.
    req_valid4 = 4'b1011;
    #1;
    check("r4_rot3", req_ready4, 4'b1000);
    check("r4_busy0", busy4, 1'b1);
    tick();
    check("r4_rot0", req_ready4, 4'b0001);
    tick();
    check("r4_rot1", req_ready4, 4'b0010);
    tick();
    check("r4_rot3b", req_ready4, 4'b1000);
    tick();
    req_valid4 = 4'b0000;
    #1;
    check("r4_busy1", busy4, 1'b1);
    tick();
    check("r4_busy2", busy4, 1'b1);
    tick();
    check("r4_busy3", busy4, 1'b1);
    tick();
    check("r4_busy4", busy4, 1'b0);

    // Three back-to-back grants (last grant 1 -> 0,1,0), then a one-cycle reset.
    req_valid = 2'b11;
    tick(); tick(); tick();
    req_valid = 2'b00;
    rst_in    = 1'b0;
    tick();
    rst_in = 1'b1;
    check("mid_dpv",  dp_valid, 1'b0);
    check("mid_dpd",  dp_data,  16'h0000);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("mid_rsp%0d", i), rsp_valid, 2'b00);
      check($sformatf("mid_busy%0d", i), busy, 1'b0);
      tick();
    end
    req_valid = 2'b11;
    #1;
    check("mid_lastgrant", req_ready, 2'b01);

`ifdef PIPE_ARB_CNT_EN
    rst_in    = 1'b0;
    req_valid = 2'b01;
    tick();
    rst_in = 1'b1;
    check("cnt_clear0", grant_cnt[0], 16'h0000);
    for (int i = 0; i < 70000; i++) tick();
    check("cnt_sat0", grant_cnt[0], 16'hFFFF);
    check("cnt_zero1", grant_cnt[1], 16'h0000);
    req_valid = 2'b00;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
